fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and fetch FSM states.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      RUN,
      HOLD,
      HALTED
   } fetch_state_t;

   localparam word_t PC_STEP = 32'd4;
   localparam word_t WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, one-entry stall buffer and RUN/HOLD/HALTED FSM
// feeding the IF/DC register.
module fetch_unit
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   input  logic        halt,
   output logic [31:0] instr_o,
   output logic [31:0] npc_o,
   output logic        pipe_en_o,
   output logic        flush_o
);

   fetch_state_t state;
   word_t        pc;
   word_t        pc_inc;
   word_t        target;
   word_t        buf_instr;
   word_t        buf_npc;

   assign imemaddr = {pc[31:2], 2'b00};
   assign pc_inc   = pc + PC_STEP;
   assign target   = redirect_pc & WORD_MASK;

   always_comb begin
      imemREN   = 1'b0;
      pipe_en_o = 1'b0;
      flush_o   = 1'b0;
      instr_o   = imemload;
      npc_o     = pc_inc;
      case (state)
         RUN: begin
            imemREN = 1'b1;
            if (redirect_en || halt) begin
               flush_o = 1'b1;
            end else if (!stall) begin
               // no data and no stall: push a bubble
               if (ihit) pipe_en_o = 1'b1;
               else      flush_o   = 1'b1;
            end
         end
         HOLD: begin
            instr_o = buf_instr;
            npc_o   = buf_npc;
            if (redirect_en || halt) flush_o   = 1'b1;
            else if (!stall)         pipe_en_o = 1'b1;
         end
         default: flush_o = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= RUN;
         pc        <= PC_INIT;
         buf_instr <= '0;
         buf_npc   <= '0;
      end else begin
         case (state)
            RUN: begin
               if (redirect_en) begin
                  pc <= target;
               end else if (halt) begin
                  state <= HALTED;
               end else if (ihit) begin
                  pc <= pc_inc;
                  if (stall) begin
                     buf_instr <= imemload;
                     buf_npc   <= pc_inc;
                     state     <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (redirect_en) begin
                  pc        <= target;
                  buf_instr <= '0;
                  buf_npc   <= '0;
                  state     <= RUN;
               end else if (halt) begin
                  state <= HALTED;
               end else if (!stall) begin
                  state <= RUN;
               end
            end
            default: state <= HALTED;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural model predicts each cycle's
// outputs, which are queued at drive time and compared once the DUT settles.
module tb_fetch_unit;

   typedef logic [31:0] word_t;

   typedef struct {
      logic  ren;
      word_t addr;
      logic  pe;
      logic  fl;
      logic  fl_dc;
      word_t instr;
      word_t npc;
   } exp_t;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        ihit;
   logic [31:0] imemload;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        halt;

   logic        imemREN,   ren2;
   logic [31:0] imemaddr,  addr2;
   logic [31:0] instr_o,   instr2;
   logic [31:0] npc_o,     npc2;
   logic        pipe_en_o, pe2;
   logic        flush_o,   fl2;

   int    n_cmp = 0;
   int    n_bad = 0;
   exp_t  sb[$];
   int    m_st;
   word_t m_pc, m_buf, m_bnpc;

   always #5 CLK = ~CLK;

   fetch_unit dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
      .imemREN(imemREN), .imemaddr(imemaddr),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .stall(stall), .halt(halt),
      .instr_o(instr_o), .npc_o(npc_o),
      .pipe_en_o(pipe_en_o), .flush_o(flush_o)
   );

   fetch_unit #(.PC_INIT(32'hFFFF_FFFC)) dut2 (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
      .imemREN(ren2), .imemaddr(addr2),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .stall(stall), .halt(halt),
      .instr_o(instr2), .npc_o(npc2),
      .pipe_en_o(pe2), .flush_o(fl2)
   );

   function automatic word_t mem(word_t a);
      return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1};
   endfunction

   task automatic chk(string tag, word_t got, word_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      nRST = 1'b0;
      ihit = 1'b0; stall = 1'b0; halt = 1'b0;
      redirect_en = 1'b0; redirect_pc = '0; imemload = '0;
      m_st = 0; m_pc = '0; m_buf = '0; m_bnpc = '0;
      #1;
      chk("rst_ren",  {31'd0, imemREN}, 32'd1);
      chk("rst_addr", imemaddr, 32'h0);
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   task automatic step(logic h, logic s, logic r, word_t rpc, logic ht);
      exp_t e;
      @(negedge CLK);
      ihit = h; stall = s; halt = ht;
      redirect_en = r; redirect_pc = rpc;
      imemload = h ? mem(m_pc) : 32'hDEAD_BEEF;
      e = '{ren: 1'b0, addr: {m_pc[31:2], 2'b00}, pe: 1'b0, fl: 1'b0,
             fl_dc: 1'b0, instr: '0, npc: '0};
      if (m_st == 0) begin
         e.ren = 1'b1;
         if (r) begin
            e.fl = 1'b1;
            m_pc = {rpc[31:2], 2'b00};
         end else if (ht) begin
            e.fl_dc = 1'b1;
            m_st = 2;
         end else if (h && !s) begin
            e.pe = 1'b1;
            e.instr = mem(m_pc);
            e.npc = m_pc + 32'd4;
            m_pc = m_pc + 32'd4;
         end else if (h) begin
            m_buf = mem(m_pc);
            m_bnpc = m_pc + 32'd4;
            m_pc = m_pc + 32'd4;
            m_st = 1;
         end else if (!s) begin
            e.fl = 1'b1;
         end
      end else if (m_st == 1) begin
         if (r) begin
            e.fl = 1'b1;
            m_pc = {rpc[31:2], 2'b00};
            m_st = 0;
         end else if (ht) begin
            e.fl_dc = 1'b1;
            m_st = 2;
         end else if (!s) begin
            e.pe = 1'b1;
            e.instr = m_buf;
            e.npc = m_bnpc;
            m_st = 0;
         end
      end else begin
         e.fl = 1'b1;
      end
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      chk("ren",  {31'd0, imemREN}, {31'd0, e.ren});
      chk("addr", imemaddr, e.addr);
      chk("pipe_en", {31'd0, pipe_en_o}, {31'd0, e.pe});
      if (!e.fl_dc) chk("flush", {31'd0, flush_o}, {31'd0, e.fl});
      if (e.pe) begin
         chk("instr", instr_o, e.instr);
         chk("npc",   npc_o,   e.npc);
      end
   endtask

   initial begin
      nRST = 1'b0;
      ihit = 1'b0; stall = 1'b0; halt = 1'b0;
      redirect_en = 1'b0; redirect_pc = '0; imemload = '0;
      do_reset();

      step(1, 0, 0, 0, 0);
      chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
      chk("wrap_npc0",  npc2,  32'h0);
      step(1, 0, 0, 0, 0);
      chk("wrap_addr1", addr2, 32'h0);
      repeat (4) step(1, 0, 0, 0, 0);

      do_reset();
      repeat (4) step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);

      step(1, 1, 0, 0, 0);
      step(0, 0, 1, 32'h103, 0);
      step(1, 0, 0, 0, 0);

      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);

      step(1, 1, 0, 0, 0);
      do_reset();
      step(1, 0, 0, 0, 0);

      step(1, 0, 1, 32'h200, 1);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1);
      step(1, 0, 1, 32'h300, 0);
      step(1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      do_reset();
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
